fp_add_align: RTL and testbench

Operand-alignment stage of the single-precision IEEE 754 add/sub datapath. It sits directly upstream of the carry-lookahead mantissa adder. It unpacks two operands, orders them by magnitude, and right-shifts the smaller significand with guard/round/sticky bits. It also resolves NaN/Inf cases as a bypass. The block is a 2-stage valid/ready pipeline, so the adder always receives aligned, same-exponent significands.

---
 rtl/fp_add_align.sv | 157 +++++++++++++++
 tb/tb_fp_add_align.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fp_add_align.sv
// Binary32 add/sub operand alignment: unpack, order by magnitude, right-shift the
// smaller significand with guard/round/sticky, and bypass NaN/Inf. Two-stage valid/ready pipe.
module fp_add_align #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a_in,
  input  logic [EXP_W+FRAC_W:0]   b_in,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FRAC_W+3:0]       big_man,
  output logic [FRAC_W+3:0]       small_man,
  output logic [EXP_W-1:0]        exp_out,
  output logic                    sign_out,
  output logic                    eff_sub,
  output logic                    special,
  output logic [EXP_W+FRAC_W:0]   special_res
);

  localparam int W     = EXP_W + FRAC_W + 1;
  localparam int SIG_W = FRAC_W + 1;
  localparam int MAN_W = FRAC_W + 4;
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] MAN_W_EXP = EXP_W'(MAN_W);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

  logic adv1, adv2;

  // S1 input-side decode
  logic              sa, sb_eff, swap, eff_d;
  logic [EXP_W-1:0]  ea, eb, ea_w, eb_w, exp_l, exp_s;
  logic [FRAC_W-1:0] fa, fb;
  logic [SIG_W-1:0]  siga, sigb;
  logic              a_spec, b_spec, a_nan, b_nan, a_inf, b_inf;
  logic [W-1:0]      res_d;

  logic              s1_valid_q, s1_sign_q, s1_eff_q, s1_spec_q;
  logic [SIG_W-1:0]  s1_big_q, s1_small_q;
  logic [EXP_W-1:0]  s1_exp_q, s1_d_q;
  logic [W-1:0]      s1_res_q;

  logic              s2_valid_q, s2_sign_q, s2_eff_q, s2_spec_q;
  logic [MAN_W-1:0]  s2_big_q, s2_small_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [W-1:0]      s2_res_q;

  logic [MAN_W-1:0]  ext, shifted, lost, small_d, big_d;

  always_comb begin
    sa     = a_in[W-1];
    sb_eff = b_in[W-1] ^ sub;
    eff_d  = sa ^ sb_eff;
    ea     = a_in[W-2:FRAC_W];
    eb     = b_in[W-2:FRAC_W];
    fa     = a_in[FRAC_W-1:0];
    fb     = b_in[FRAC_W-1:0];
    ea_w   = (ea == '0) ? EXP_ONE : ea;
    eb_w   = (eb == '0) ? EXP_ONE : eb;
    siga   = {|ea, fa};
    sigb   = {|eb, fb};
    swap   = b_in[W-2:0] > a_in[W-2:0];
    exp_l  = swap ? eb_w : ea_w;
    exp_s  = swap ? ea_w : eb_w;
    a_spec = (ea == EXP_MAX);
    b_spec = (eb == EXP_MAX);
    a_nan  = a_spec & (|fa);
    b_nan  = b_spec & (|fb);
    a_inf  = a_spec & ~(|fa);
    b_inf  = b_spec & ~(|fb);
    res_d  = '0;
    if (a_nan | b_nan | (a_inf & b_inf & eff_d)) res_d = QNAN;
    else if (a_inf)                              res_d = {sa, EXP_MAX, {FRAC_W{1'b0}}};
    else if (b_inf)                              res_d = {sb_eff, EXP_MAX, {FRAC_W{1'b0}}};
  end

  // Once d reaches the full width, every bit lands in sticky.
  always_comb begin
    ext     = {s1_small_q, 3'b000};
    shifted = ext >> s1_d_q;
    lost    = ext & ~({MAN_W{1'b1}} << s1_d_q);
    if (s1_d_q >= MAN_W_EXP) small_d = {{(MAN_W-1){1'b0}}, |s1_small_q};
    else                     small_d = shifted | {{(MAN_W-1){1'b0}}, |lost};
    big_d = {s1_big_q, 3'b000};
    if (s1_spec_q) begin
      small_d = '0;
      big_d   = '0;
    end
  end

  assign adv2     = out_ready | ~s2_valid_q;
  assign adv1     = adv2 | ~s1_valid_q;
  assign in_ready = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_eff_q   <= 1'b0;
      s1_spec_q  <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_exp_q   <= '0;
      s1_d_q     <= '0;
      s1_res_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_eff_q   <= 1'b0;
      s2_spec_q  <= 1'b0;
      s2_big_q   <= '0;
      s2_small_q <= '0;
      s2_exp_q   <= '0;
      s2_res_q   <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q  <= swap ? sb_eff : sa;
          s1_eff_q   <= eff_d;
          s1_spec_q  <= a_spec | b_spec;
          s1_big_q   <= swap ? sigb : siga;
          s1_small_q <= swap ? siga : sigb;
          s1_exp_q   <= exp_l;
          s1_d_q     <= exp_l - exp_s;
          s1_res_q   <= res_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q  <= s1_sign_q;
          s2_eff_q   <= s1_eff_q;
          s2_spec_q  <= s1_spec_q;
          s2_big_q   <= big_d;
          s2_small_q <= small_d;
          s2_exp_q   <= s1_spec_q ? '0 : s1_exp_q;
          s2_res_q   <= s1_res_q;
        end
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign big_man     = s2_big_q;
  assign small_man   = s2_small_q;
  assign exp_out     = s2_exp_q;
  assign sign_out    = s2_sign_q;
  assign eff_sub     = s2_eff_q;
  assign special     = s2_spec_q;
  assign special_res = s2_res_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed bench for fp_add_align: alignment vectors, specials, backpressure and reset.
module tb_fp_add_align;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a_in, b_in, special_res;
  logic [26:0] big_man, small_man;
  logic [7:0]  exp_out;
  logic        sign_out, eff_sub, special;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .big_man(big_man), .small_man(small_man), .exp_out(exp_out), .sign_out(sign_out),
    .eff_sub(eff_sub), .special(special), .special_res(special_res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one pair on an empty pipe and checks it two edges later.
  task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [26:0] e_big, input logic [26:0] e_small, input logic [7:0] e_exp,
                        input logic e_sign, input logic e_eff, input logic chk_se,
                        input logic e_spec, input logic [31:0] e_res);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in = a; b_in = b; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_big"}, 32'(big_man), 32'(e_big));
    check({tag, "_small"}, 32'(small_man), 32'(e_small));
    check({tag, "_exp"}, 32'(exp_out), 32'(e_exp));
    check({tag, "_spec"}, 32'(special), 32'(e_spec));
    check({tag, "_res"}, special_res, e_res);
    if (chk_se) begin
      check({tag, "_sign"}, 32'(sign_out), 32'(e_sign));
      check({tag, "_eff"}, 32'(eff_sub), 32'(e_eff));
    end
  endtask

  logic [31:0] bp_pair [4] = '{32'h3800_0000, 32'h3880_0000, 32'h3900_0000, 32'h3980_0000};
  int idx, oidx, first_c, last_c;
  logic acc, xfer;
  logic [7:0] got_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_big", 32'(big_man), 32'd0);
    check("rst_small", 32'(small_man), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_res", special_res, 32'd0);

    do_vec("eq_exp", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 27'h400_0000, 27'h400_0000, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_vec("swap", 32'h3F80_0000, 32'hC000_0000, 1'b0, 27'h400_0000, 27'h200_0000, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    do_vec("sticky26", 32'h3F80_0001, 32'h4C80_0000, 1'b0, 27'h400_0000, 27'h1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_vec("sticky30", 32'h3F80_0001, 32'h4E80_0000, 1'b0, 27'h400_0000, 27'h1, 8'h9D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_vec("tie_sub", 32'hBF80_0000, 32'hBF80_0000, 1'b1, 27'h400_0000, 27'h400_0000, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    do_vec("denorm", 32'h0000_0001, 32'h0000_0000, 1'b0, 27'h8, 27'h0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_vec("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 27'h0, 27'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);
    do_vec("inf_p_one", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 27'h0, 27'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7F80_0000);
    do_vec("one_m_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 27'h0, 27'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFF80_0000);
    do_vec("nan_a", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 27'h0, 27'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);
    do_vec("nan_b", 32'h3F80_0000, 32'h7F80_0001, 1'b0, 27'h0, 27'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000);

    // Backpressure: fill the pipe with out_ready low, then drain.
    @(posedge clk); #1;
    out_ready = 1'b0; sub = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      a_in = bp_pair[idx < 4 ? idx : 0];
      b_in = a_in;
      #0;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head", 32'(exp_out), 32'h70);
    @(posedge clk); #1;
    check("bp_hold", 32'(exp_out), 32'h70);
    out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    oidx = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 4);
      a_in = bp_pair[idx < 4 ? idx : 0];
      b_in = a_in;
      #0;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      got_exp = exp_out;
      @(posedge clk); #1;
      if (xfer) begin
        check("bp_order", 32'(got_exp), 32'(8'h70 + 8'(oidx)));
        if (first_c < 0) first_c = c;
        last_c = c;
        oidx++;
      end
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(oidx), 32'd4);
    check("bp_back2back", 32'(last_c - first_c), 32'd3);

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a_in = 32'h3F80_0000; b_in = 32'h4000_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rm_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_in_ready", 32'(in_ready), 32'd1);
    check("rm_big", 32'(big_man), 32'd0);
    check("rm_small", 32'(small_man), 32'd0);
    check("rm_exp", 32'(exp_out), 32'd0);
    do_vec("post_rst", 32'h3F80_0000, 32'hC000_0000, 1'b0, 27'h400_0000, 27'h200_0000, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
